// File: rtl/arm_dp_ctrl_syn.sv
// ============================================================================
// Module   : arm_dp_ctrl_syn
// Brief    : Three-state sequencer for the 4-bit ARM data-processing datapath.
// Revision : 1.0
// ============================================================================
`default_nettype none

module arm_dp_ctrl_syn (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [3:0] instr_cond,
  input  logic [3:0] instr_opcode,
  input  logic       instr_s,
  input  logic [2:0] instr_rd,
  input  logic [2:0] instr_rn,
  input  logic [2:0] instr_rm,
  input  logic       instr_imm_en,
  input  logic [3:0] instr_imm,
  output logic [3:0] alu_op1,
  output logic [3:0] alu_op2,
  output logic [3:0] alu_op_sel,
  input  logic [3:0] alu_out,
  input  logic [3:0] alu_flags,
  output logic       done,
  output logic       executed,
  output logic       instr_err,
  output logic [3:0] cpsr,
  input  logic       host_we,
  input  logic [2:0] host_waddr,
  input  logic [3:0] host_wdata,
  input  logic [2:0] dbg_raddr,
  output logic [3:0] dbg_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_e;

  state_e     state_q;
  logic [3:0] regs_q [8];
  logic [3:0] cpsr_q;
  logic [3:0] opc_q;
  logic [3:0] op1_q;
  logic [3:0] op2_q;
  logic       s_q;
  logic [2:0] rd_q;
  logic       exec_q;
  logic       err_q;
  logic       done_q;
  logic       executed_q;
  logic       instr_err_q;

  logic       accept;
  logic       illegal;
  logic       cmp_op;
  logic       arith_op;
  logic [3:0] op2_sel;

  // Condition evaluated against {N,Z,C,V}.
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    case (c)
      4'h0:    return z;
      4'h1:    return ~z;
      4'h2:    return cy;
      4'h3:    return ~cy;
      4'h4:    return n;
      4'h5:    return ~n;
      4'h6:    return v;
      4'h7:    return ~v;
      4'h8:    return cy & ~z;
      4'h9:    return ~cy | z;
      4'hA:    return n == v;
      4'hB:    return n != v;
      4'hC:    return ~z & (n == v);
      4'hD:    return z | (n != v);
      4'hE:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign instr_ready = (state_q == S_IDLE) & ~host_we;
  assign accept      = instr_valid & instr_ready;
  assign illegal     = instr_opcode inside {4'h5, 4'h6, 4'h7};
  assign op2_sel     = instr_imm_en ? instr_imm : regs_q[instr_rm];
  assign cmp_op      = (opc_q[3:2] == 2'b10);
  assign arith_op    = opc_q inside {4'h2, 4'h3, 4'h4, 4'hA, 4'hB};

  assign alu_op1    = op1_q;
  assign alu_op2    = op2_q;
  assign alu_op_sel = opc_q;
  assign done       = done_q;
  assign executed   = executed_q;
  assign instr_err  = instr_err_q;
  assign cpsr       = cpsr_q;
  assign dbg_rdata  = regs_q[dbg_raddr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < 8; i++) regs_q[i] <= 4'd0;
      cpsr_q      <= 4'd0;
      opc_q       <= 4'd0;
      op1_q       <= 4'd0;
      op2_q       <= 4'd0;
      s_q         <= 1'b0;
      rd_q        <= 3'd0;
      exec_q      <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      executed_q  <= 1'b0;
      instr_err_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (host_we) begin
            regs_q[host_waddr] <= host_wdata;
          end else if (accept) begin
            opc_q   <= instr_opcode;
            op1_q   <= regs_q[instr_rn];
            op2_q   <= op2_sel;
            s_q     <= instr_s;
            rd_q    <= instr_rd;
            err_q   <= illegal;
            exec_q  <= ~illegal & cond_pass(instr_cond, cpsr_q);
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (exec_q) begin
            if (!cmp_op) regs_q[rd_q] <= alu_out;
            // Logical ops keep the architectural C and V.
            if (s_q | cmp_op)
              cpsr_q <= arith_op ? alu_flags : {alu_flags[3:2], cpsr_q[1:0]};
          end
          done_q      <= 1'b1;
          executed_q  <= exec_q;
          instr_err_q <= err_q;
          state_q     <= S_WB;
        end
        S_WB: begin
          done_q      <= 1'b0;
          executed_q  <= 1'b0;
          instr_err_q <= 1'b0;
          opc_q       <= 4'd0;
          op1_q       <= 4'd0;
          op2_q       <= 4'd0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_arm_dp_ctrl_syn.sv
// ============================================================================
// Module   : tb_arm_dp_ctrl_syn
// Brief    : Scoreboard bench for arm_dp_ctrl_syn with a behavioural ALU.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_arm_dp_ctrl_syn;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [3:0] instr_cond = 4'd0;
  logic [3:0] instr_opcode = 4'd0;
  logic       instr_s = 1'b0;
  logic [2:0] instr_rd = 3'd0;
  logic [2:0] instr_rn = 3'd0;
  logic [2:0] instr_rm = 3'd0;
  logic       instr_imm_en = 1'b0;
  logic [3:0] instr_imm = 4'd0;
  logic [3:0] alu_op1, alu_op2, alu_op_sel;
  logic [3:0] alu_out, alu_flags;
  logic       done, executed, instr_err;
  logic [3:0] cpsr;
  logic       host_we = 1'b0;
  logic [2:0] host_waddr = 3'd0;
  logic [3:0] host_wdata = 4'd0;
  logic [2:0] dbg_raddr = 3'd0;
  logic [3:0] dbg_rdata;

  arm_dp_ctrl_syn dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_cond(instr_cond), .instr_opcode(instr_opcode), .instr_s(instr_s),
    .instr_rd(instr_rd), .instr_rn(instr_rn), .instr_rm(instr_rm),
    .instr_imm_en(instr_imm_en), .instr_imm(instr_imm),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_op_sel(alu_op_sel),
    .alu_out(alu_out), .alu_flags(alu_flags),
    .done(done), .executed(executed), .instr_err(instr_err), .cpsr(cpsr),
    .host_we(host_we), .host_waddr(host_waddr), .host_wdata(host_wdata),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       ex;
    logic       err;
    logic [3:0] cpsr;
    logic [2:0] rd;
    logic [3:0] rdv;
    logic [3:0] op1;
    logic [3:0] op2;
    logic [3:0] sel;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] m_regs [8];
  logic [3:0] m_cpsr;

  // Behavioural ALU: {result, N, Z, C, V}. Logical ops return arbitrary C/V.
  function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic [3:0] op);
    logic [4:0] t;
    logic [3:0] r;
    logic c, v;
    c = ^a;
    v = ^b;
    case (op)
      4'h0, 4'h8: r = a & b;
      4'h1, 4'h9: r = a ^ b;
      4'h2, 4'hA: begin
        t = {1'b0, a} + {1'b0, ~b} + 5'd1;
        r = t[3:0]; c = t[4]; v = (a[3] != b[3]) && (r[3] != a[3]);
      end
      4'h3: begin
        t = {1'b0, b} + {1'b0, ~a} + 5'd1;
        r = t[3:0]; c = t[4]; v = (a[3] != b[3]) && (r[3] != b[3]);
      end
      4'h4, 4'hB: begin
        t = {1'b0, a} + {1'b0, b};
        r = t[3:0]; c = t[4]; v = (a[3] == b[3]) && (r[3] != a[3]);
      end
      4'hC:    r = a | b;
      4'hD:    r = b;
      4'hE:    r = a & ~b;
      4'hF:    r = ~b;
      default: r = ~a;
    endcase
    return {r, r[3], (r == 4'd0), c, v};
  endfunction

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always_comb {alu_out, alu_flags} = alu_f(alu_op1, alu_op2, alu_op_sel);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic dbg_check(input string nm, input logic [2:0] a, input logic [3:0] exp);
    dbg_raddr = a;
    #1 check(nm, {28'd0, dbg_rdata}, {28'd0, exp});
  endtask

  task automatic host_write(input logic [2:0] a, input logic [3:0] d);
    @(negedge clk);
    host_we = 1'b1; host_waddr = a; host_wdata = d;
    #1 check("ready_during_host_we", {31'd0, instr_ready}, 32'd0);
    @(negedge clk);
    host_we = 1'b0;
    m_regs[a] = d;
    dbg_check("dbg_after_write", a, d);
  endtask

  // sync=0: caller is already positioned at a negedge.
  task automatic issue(input logic sync, input logic [3:0] cond, input logic [3:0] opc,
                       input logic s, input logic [2:0] rd, input logic [2:0] rn,
                       input logic [2:0] rm, input logic imm_en, input logic [3:0] imm);
    exp_t e;
    logic [7:0] r;
    logic cmpop;
    if (sync) @(negedge clk);
    instr_cond = cond; instr_opcode = opc; instr_s = s; instr_rd = rd;
    instr_rn = rn; instr_rm = rm; instr_imm_en = imm_en; instr_imm = imm;
    instr_valid = 1'b1;
    e.op1 = m_regs[rn];
    e.op2 = imm_en ? imm : m_regs[rm];
    e.sel = opc;
    e.err = (opc == 4'h5) || (opc == 4'h6) || (opc == 4'h7);
    e.ex  = cond_ok(cond, m_cpsr) && !e.err;
    if (e.ex) begin
      r = alu_f(e.op1, e.op2, opc);
      cmpop = (opc >= 4'h8) && (opc <= 4'hB);
      if (!cmpop) m_regs[rd] = r[7:4];
      if (s || cmpop) begin
        if (opc == 4'h2 || opc == 4'h3 || opc == 4'h4 || opc == 4'hA || opc == 4'hB)
          m_cpsr = r[3:0];
        else
          m_cpsr = {r[3:2], m_cpsr[1:0]};
      end
    end
    e.cpsr = m_cpsr; e.rd = rd; e.rdv = m_regs[rd];
    sb.push_back(e);
    #1 check("ready_idle", {31'd0, instr_ready}, 32'd1);
    @(negedge clk);
    instr_valid = 1'b0;
    check("ready_exec", {31'd0, instr_ready}, 32'd0);
    check("done_exec", {31'd0, done}, 32'd0);
    check("alu_exec", {20'd0, alu_op1, alu_op2, alu_op_sel}, {20'd0, e.op1, e.op2, e.sel});
    @(negedge clk);
    check("done_wb", {31'd0, done}, 32'd1);
    check("ready_wb", {31'd0, instr_ready}, 32'd0);
    @(negedge clk);
    check("ready_back", {31'd0, instr_ready}, 32'd1);
    check("done_cleared", {31'd0, done}, 32'd0);
    check("alu_idle_zero", {20'd0, alu_op1, alu_op2, alu_op_sel}, 32'd0);
  endtask

  // Monitor: every done pops one expected completion.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL done_spurious: got done=1, expected no pending instruction (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        check("executed", {31'd0, executed}, {31'd0, e.ex});
        check("instr_err", {31'd0, instr_err}, {31'd0, e.err});
        check("cpsr", {28'd0, cpsr}, {28'd0, e.cpsr});
        check("alu_held_wb", {20'd0, alu_op1, alu_op2, alu_op_sel}, {20'd0, e.op1, e.op2, e.sel});
        dbg_raddr = e.rd;
        #1 check("rd_value", {28'd0, dbg_rdata}, {28'd0, e.rdv});
      end
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) m_regs[i] = 4'd0;
    m_cpsr = 4'd0;
    #1;
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_flags_out", {30'd0, executed, instr_err}, 32'd0);
    check("rst_alu", {20'd0, alu_op1, alu_op2, alu_op_sel}, 32'd0);
    check("rst_ready", {31'd0, instr_ready}, 32'd1);
    check("rst_cpsr", {28'd0, cpsr}, 32'd0);
    dbg_check("rst_r0", 3'd0, 4'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // ADD 7+1 with S: R3=8, N and V set.
    host_write(3'd1, 4'd7);
    host_write(3'd2, 4'd1);
    issue(1, 4'hE, 4'h4, 1, 3'd3, 3'd1, 3'd2, 0, 4'd0);
    check("tp_add_cpsr", {28'd0, cpsr}, 32'h9);
    dbg_check("tp_add_r3", 3'd3, 4'h8);

    // SUB 3-3 with S, then MOVEQ.
    host_write(3'd1, 4'd3);
    issue(1, 4'hE, 4'h2, 1, 3'd4, 3'd1, 3'd0, 1, 4'd3);
    check("tp_sub_cpsr", {28'd0, cpsr}, 32'h6);
    dbg_check("tp_sub_r4", 3'd4, 4'h0);
    issue(1, 4'h0, 4'hD, 0, 3'd5, 3'd0, 3'd0, 1, 4'hA);
    dbg_check("tp_moveq_r5", 3'd5, 4'hA);

    // Clear Z (logical MOVS keeps C), then MOVEQ must not execute.
    issue(1, 4'hE, 4'hD, 1, 3'd0, 3'd0, 3'd0, 1, 4'h1);
    check("tp_movs_cpsr", {28'd0, cpsr}, 32'h2);
    issue(1, 4'h0, 4'hD, 0, 3'd6, 3'd0, 3'd0, 1, 4'hF);
    check("tp_skip_cpsr", {28'd0, cpsr}, 32'h2);
    dbg_check("tp_skip_r6", 3'd6, 4'h0);

    // CMP without S still sets flags, no writeback.
    host_write(3'd1, 4'd5);
    host_write(3'd2, 4'd5);
    issue(1, 4'hE, 4'hA, 0, 3'd3, 3'd1, 3'd2, 0, 4'd0);
    check("tp_cmp_cpsr", {28'd0, cpsr}, 32'h6);
    dbg_check("tp_cmp_r3", 3'd3, 4'h8);

    // Undefined ADC.
    issue(1, 4'hE, 4'h5, 1, 3'd0, 3'd1, 3'd2, 0, 4'd0);
    check("tp_adc_cpsr", {28'd0, cpsr}, 32'h6);
    dbg_check("tp_adc_r0", 3'd0, 4'h1);

    // Host write wins over a simultaneous instruction offer.
    @(negedge clk);
    host_we = 1'b1; host_waddr = 3'd2; host_wdata = 4'd9;
    instr_cond = 4'hE; instr_opcode = 4'h4; instr_s = 1'b0; instr_rd = 3'd7;
    instr_rn = 3'd2; instr_rm = 3'd2; instr_imm_en = 1'b0; instr_valid = 1'b1;
    #1 check("tp_collide_ready", {31'd0, instr_ready}, 32'd0);
    @(negedge clk);
    host_we = 1'b0;
    m_regs[2] = 4'd9;
    issue(0, 4'hE, 4'h4, 0, 3'd7, 3'd2, 3'd2, 0, 4'd0);
    dbg_check("tp_collide_r7", 3'd7, 4'h2);

    // Reset during EXEC aborts the instruction.
    host_write(3'd1, 4'd6);
    @(negedge clk);
    instr_cond = 4'hE; instr_opcode = 4'h4; instr_s = 1'b1; instr_rd = 3'd1;
    instr_rn = 3'd1; instr_rm = 3'd1; instr_imm_en = 1'b0; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_alu", {20'd0, alu_op1, alu_op2, alu_op_sel}, 32'd0);
    check("abort_cpsr", {28'd0, cpsr}, 32'd0);
    check("abort_ready", {31'd0, instr_ready}, 32'd1);
    dbg_check("abort_r1", 3'd1, 4'd0);
    dbg_check("abort_r5", 3'd5, 4'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) m_regs[i] = 4'd0;
    m_cpsr = 4'd0;
    repeat (4) @(negedge clk);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 4) == 0)
        host_write(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
      else
        issue(1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
